logic_unit_arbiter: RTL and testbench
=====================================

# logic_unit_arbiter

Sequencer and two-port round-robin arbiter for the shared 8-bit bitwise logic unit. Two requesters (e.g. instruction decode and address/flag logic) submit AND/OR operations. The arbiter picks one and drives the logic unit's operand and mode inputs. It then enables the unit's tri-state outputs for exactly one cycle, captures result and flags, and returns them with the requester ID. It sits between the requesters and the logic unit and is the only block allowed to assert the unit's output enable.

## Interface
- DATA_WIDTH, 8, operand/result width
- FLAG_WIDTH, 4, flag bus width (bit0 zero, bit1 negative, bits 3:2 pass-through)

- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- req0 / req1  in  1  operation request from requester 0 / 1; held until matching gnt
- op0 / op1  in  1  mode for requester 0 / 1: 1 = AND, 0 = OR
- a0, b0 / a1, b1  in  DATA_WIDTH  primary / secondary operands per requester
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted, operands latched
- lu_and_or  out  1  mode to logic unit
- lu_primary, lu_secondary  out  DATA_WIDTH  operands to logic unit
- lu_oe  out  1  logic-unit output enable
- lu_result  in  DATA_WIDTH  logic-unit result bus (tri-state, valid only while lu_oe=1)
- lu_flags  in  FLAG_WIDTH  logic-unit flag bus (tri-state)
- rsp_valid  out  1  one-cycle pulse: rsp_* valid
- rsp_id  out  1  requester that owns the response
- rsp_result  out  DATA_WIDTH  captured result
- rsp_flags  out  FLAG_WIDTH  captured flags
- busy  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ISSUE, READ, RESP.
- IDLE, no req: stay in IDLE. Outputs remain 0.
- IDLE with any req: on the clock edge, select the winner, latch its op/a/b into internal registers, pulse gnt of the winner, set rsp_id to the winner, go to ISSUE.
- Arbitration when only one request is asserted: that requester wins.
- Arbitration when both requests are asserted: the requester not granted last wins. last_grant updates on every grant. last_grant resets to 1, so req0 wins the first contested cycle.
- ISSUE: lu_and_or, lu_primary and lu_secondary are driven from the latched registers. They hold these values through ISSUE and READ. The logic unit registers the operation on the edge that ends ISSUE. Next state is READ.
- READ: lu_oe=1. On the edge that ends READ, capture lu_result into rsp_result and lu_flags into rsp_flags. Next state is RESP.
- RESP: rsp_valid=1 for one cycle. Next state is IDLE. Requests are not sampled in RESP.
- lu_oe is 1 only in READ and 0 in every other state, including reset, so the unit never drives the shared bus otherwise.
- rsp_result, rsp_flags and rsp_id hold their values until the next capture.
- Requester rule: drop req during the cycle gnt is high. A req still high when the FSM returns to IDLE is treated as a new request.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1.
  - gnt0, gnt1, lu_oe, rsp_valid, busy, rsp_id, lu_and_or = 0.
  - lu_primary, lu_secondary, rsp_result, rsp_flags = 0.
- Reset mid-operation: immediate return to IDLE. The aborted operation produces no rsp_valid, and lu_oe drops asynchronously.
- Let edge 0 be the edge where req is sampled high in IDLE:
  - gnt is high in cycle 1, and state is ISSUE.
  - lu_oe is high in cycle 2 (READ).
  - rsp_valid is high in cycle 3 (RESP).
  - The next grant is possible at edge 4 at the earliest.
- Latency is 3 cycles from sampling to response. Sustained throughput is one operation per 4 cycles.
- Both requesters held high continuously: grants alternate 0,1,0,1, each spaced 4 cycles apart.
- Operand changes on a0/b0/a1/b1 after the grant edge have no effect on the operation in flight.

## Test plan
- Reset, then req0=1, op0=1, a0=8'hF0, b0=8'h3C: gnt0 in cycle 1; lu_oe only in cycle 2; rsp_valid in cycle 3 with rsp_id=0, rsp_result=8'h30.
- req1 only, op1=0, a1=8'h00, b1=8'h00 (model unit returns 0 with flags=4'b0001): rsp_id=1, rsp_result=8'h00, rsp_flags=4'b0001.
- req0 and req1 held high for 16 cycles: grants in the order 0,1,0,1, at edges 0, 4, 8, 12; rsp_id sequence matches.
- Change a0 to 8'hFF in the cycle after gnt0 (original a0=8'h0F, b0=8'hFF, AND): rsp_result=8'h0F.
- Assert reset during READ: lu_oe drops at once; no rsp_valid follows; the next contested request is granted to req0.
- Over all scenarios: lu_oe is never high outside READ, and gnt0 and gnt1 are never high together.

Source files
------------

// File: rtl/logic_unit_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | logic_unit_arbiter_if                                                       |
// | Requester, logic-unit and response signals of the shared logic unit arbiter.|
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface logic_unit_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int FLAG_WIDTH = 4
);
  logic                  req0;
  logic                  req1;
  logic                  op0;
  logic                  op1;
  logic [DATA_WIDTH-1:0] a0;
  logic [DATA_WIDTH-1:0] b0;
  logic [DATA_WIDTH-1:0] a1;
  logic [DATA_WIDTH-1:0] b1;
  logic                  gnt0;
  logic                  gnt1;
  logic                  lu_and_or;
  logic [DATA_WIDTH-1:0] lu_primary;
  logic [DATA_WIDTH-1:0] lu_secondary;
  logic                  lu_oe;
  logic [DATA_WIDTH-1:0] lu_result;
  logic [FLAG_WIDTH-1:0] lu_flags;
  logic                  rsp_valid;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic [FLAG_WIDTH-1:0] rsp_flags;
  logic                  busy;

  // Arbiter side
  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, lu_result, lu_flags,
    output gnt0, gnt1, lu_and_or, lu_primary, lu_secondary, lu_oe,
           rsp_valid, rsp_id, rsp_result, rsp_flags, busy
  );

  // Requester side
  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1,
    input  gnt0, gnt1, rsp_valid, rsp_id, rsp_result, rsp_flags, busy
  );

  // Logic unit side
  modport unit (
    input  lu_and_or, lu_primary, lu_secondary, lu_oe,
    output lu_result, lu_flags
  );
endinterface
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | logic_unit_arbiter                                                          |
// | Round-robin two-port sequencer for the shared 8-bit AND/OR logic unit.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module logic_unit_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int FLAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  logic_unit_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_READ  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q;
  logic                  last_grant_q;
  logic                  gnt0_q;
  logic                  gnt1_q;
  logic                  lu_oe_q;
  logic                  rsp_valid_q;
  logic                  busy_q;
  logic                  rsp_id_q;
  logic                  and_or_q;
  logic [DATA_WIDTH-1:0] primary_q;
  logic [DATA_WIDTH-1:0] secondary_q;
  logic [DATA_WIDTH-1:0] rsp_result_q;
  logic [FLAG_WIDTH-1:0] rsp_flags_q;

  logic                  any_req_d;
  logic                  winner_d;

  // On a contested cycle the requester not granted last time wins.
  always_comb begin
    any_req_d = bus.req0 | bus.req1;
    winner_d  = (bus.req0 & bus.req1) ? ~last_grant_q : bus.req1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      lu_oe_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      rsp_id_q     <= 1'b0;
      and_or_q     <= 1'b0;
      primary_q    <= '0;
      secondary_q  <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req_d) begin
            state_q      <= S_ISSUE;
            busy_q       <= 1'b1;
            gnt0_q       <= ~winner_d;
            gnt1_q       <= winner_d;
            last_grant_q <= winner_d;
            rsp_id_q     <= winner_d;
            and_or_q     <= winner_d ? bus.op1 : bus.op0;
            primary_q    <= winner_d ? bus.a1  : bus.a0;
            secondary_q  <= winner_d ? bus.b1  : bus.b0;
          end
        end
        S_ISSUE: begin
          state_q <= S_READ;
          lu_oe_q <= 1'b1;
        end
        S_READ: begin
          state_q      <= S_RESP;
          lu_oe_q      <= 1'b0;
          rsp_valid_q  <= 1'b1;
          rsp_result_q <= bus.lu_result;
          rsp_flags_q  <= bus.lu_flags;
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          lu_oe_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Operand registers double as the logic-unit drive, so they stay stable
  // through ISSUE and READ regardless of requester-side operand changes.
  assign bus.gnt0         = gnt0_q;
  assign bus.gnt1         = gnt1_q;
  assign bus.lu_and_or    = and_or_q;
  assign bus.lu_primary   = primary_q;
  assign bus.lu_secondary = secondary_q;
  assign bus.lu_oe        = lu_oe_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_flags    = rsp_flags_q;
  assign bus.busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_logic_unit_arbiter                                                       |
// | Directed and randomized checks of the logic unit arbiter against a model.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_logic_unit_arbiter;
  localparam int DW = 8;
  localparam int FW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_unit_arbiter_if #(.DATA_WIDTH(DW), .FLAG_WIDTH(FW)) bus();

  logic_unit_arbiter #(.DATA_WIDTH(DW), .FLAG_WIDTH(FW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int m_last = 1;

  // Logic unit stand-in: latches the op on the edge that ends ISSUE,
  // drives its tri-state buses only while enabled.
  logic [DW-1:0] lu_res_q = '0;
  logic [1:0]    lu_pt = 2'b00;
  always @(posedge clk)
    if (bus.gnt0 || bus.gnt1)
      lu_res_q <= bus.lu_and_or ? (bus.lu_primary & bus.lu_secondary)
                                : (bus.lu_primary | bus.lu_secondary);
  assign bus.lu_result = bus.lu_oe ? lu_res_q : 'z;
  assign bus.lu_flags  = bus.lu_oe ? {lu_pt, lu_res_q[DW-1], lu_res_q == '0} : 'z;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_res(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    return op ? (a & b) : (a | b);
  endfunction

  function automatic logic [FW-1:0] ref_flags(input logic [1:0] pt, input logic [DW-1:0] r);
    return {pt, r[DW-1], (r == 0) ? 1'b1 : 1'b0};
  endfunction

  // Bus-wide invariants, sampled every cycle.
  logic gnt_prev = 1'b0;
  always @(negedge clk) begin
    check("gnt_exclusive", {31'd0, bus.gnt0 & bus.gnt1}, 32'd0);
    check("oe_only_read", {31'd0, bus.lu_oe}, {31'd0, gnt_prev & ~rst});
    gnt_prev = bus.gnt0 | bus.gnt1;
  end

  // One full transaction; caller sits at a negedge. pat bit0=req0, bit1=req1.
  task automatic single_op(input logic [1:0] pat, input logic o0, input logic [DW-1:0] x0,
                           input logic [DW-1:0] y0, input logic o1, input logic [DW-1:0] x1,
                           input logic [DW-1:0] y1, input logic [1:0] pt);
    int w;
    logic [DW-1:0] er;
    bus.op0 = o0; bus.a0 = x0; bus.b0 = y0;
    bus.op1 = o1; bus.a1 = x1; bus.b1 = y1;
    lu_pt = pt;
    bus.req0 = pat[0]; bus.req1 = pat[1];
    w = (pat == 2'b11) ? 1 - m_last : (pat == 2'b10 ? 1 : 0);
    m_last = w;
    er = (w == 1) ? ref_res(o1, x1, y1) : ref_res(o0, x0, y0);
    @(negedge clk);
    check("gnt0_c1", {31'd0, bus.gnt0}, (w == 0) ? 32'd1 : 32'd0);
    check("gnt1_c1", {31'd0, bus.gnt1}, (w == 1) ? 32'd1 : 32'd0);
    check("busy_c1", {31'd0, bus.busy}, 32'd1);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = DW'($urandom); bus.b0 = DW'($urandom); bus.op0 = ~o0;
    bus.a1 = DW'($urandom); bus.b1 = DW'($urandom); bus.op1 = ~o1;
    @(negedge clk);
    check("rsp_valid_c2", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    check("rsp_valid_c3", {31'd0, bus.rsp_valid}, 32'd1);
    check("rsp_id", {31'd0, bus.rsp_id}, w);
    check("rsp_result", {24'd0, bus.rsp_result}, {24'd0, er});
    check("rsp_flags", {28'd0, bus.rsp_flags}, {28'd0, ref_flags(pt, er)});
    @(negedge clk);
    check("rsp_valid_c4", {31'd0, bus.rsp_valid}, 32'd0);
    check("busy_c4", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.op0 = 1'b0; bus.op1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_last = 1;
    check("rst_gnt", {30'd0, bus.gnt0, bus.gnt1}, 32'd0);
    check("rst_ctl", {28'd0, bus.lu_oe, bus.rsp_valid, bus.busy, bus.rsp_id}, 32'd0);
    check("rst_lu", {15'd0, bus.lu_and_or, bus.lu_primary, bus.lu_secondary}, 32'd0);
    check("rst_rsp", {20'd0, bus.rsp_result, bus.rsp_flags}, 32'd0);

    // Directed: AND F0/3C from port 0, OR 0/0 from port 1, operand change after grant.
    single_op(2'b01, 1'b1, 8'hF0, 8'h3C, 1'b0, 8'h00, 8'h00, 2'b00);
    single_op(2'b10, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 2'b00);
    single_op(2'b01, 1'b1, 8'h0F, 8'hFF, 1'b0, 8'h00, 8'h00, 2'b10);

    // Both requests held: grants alternate every 4 cycles.
    begin
      logic [DW-1:0] x0, y0, x1, y1;
      int cw;
      logic [DW-1:0] er;
      x0 = DW'($urandom); y0 = DW'($urandom);
      x1 = DW'($urandom); y1 = DW'($urandom);
      bus.op0 = 1'b1; bus.a0 = x0; bus.b0 = y0;
      bus.op1 = 1'b0; bus.a1 = x1; bus.b1 = y1;
      lu_pt = 2'b01;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      cw = 0;
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        if ((k - 1) % 4 == 0) begin
          cw = 1 - m_last;
          m_last = cw;
        end
        check("hold_gnt0", {31'd0, bus.gnt0}, ((k - 1) % 4 == 0 && cw == 0) ? 32'd1 : 32'd0);
        check("hold_gnt1", {31'd0, bus.gnt1}, ((k - 1) % 4 == 0 && cw == 1) ? 32'd1 : 32'd0);
        if ((k - 1) % 4 == 2) begin
          er = (cw == 1) ? ref_res(1'b0, x1, y1) : ref_res(1'b1, x0, y0);
          check("hold_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
          check("hold_rsp_id", {31'd0, bus.rsp_id}, cw);
          check("hold_rsp_result", {24'd0, bus.rsp_result}, {24'd0, er});
        end
        if (k == 15) begin
          bus.req0 = 1'b0; bus.req1 = 1'b0;
        end
      end
      check("hold_idle", {31'd0, bus.busy}, 32'd0);
    end

    // Randomized single and contested requests.
    for (int i = 0; i < 12; i++) begin
      logic [1:0] pat;
      pat = 2'($urandom_range(1, 3));
      single_op(pat, 1'($urandom), DW'($urandom), DW'($urandom),
                1'($urandom), DW'($urandom), DW'($urandom), 2'($urandom));
    end

    // Reset in READ: enable drops at once, no response, arbitration restarts.
    bus.op0 = 1'b1; bus.a0 = 8'hAA; bus.b0 = 8'h55;
    bus.req0 = 1'b1;
    @(negedge clk);
    check("abort_gnt0", {31'd0, bus.gnt0}, 32'd1);
    bus.req0 = 1'b0;
    @(negedge clk);
    check("abort_oe_read", {31'd0, bus.lu_oe}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_oe_drop", {31'd0, bus.lu_oe}, 32'd0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_last = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    single_op(2'b11, 1'b0, 8'h12, 8'h40, 1'b1, 8'hFF, 8'h81, 2'b11);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
